gpr_issue_sched: RTL
====================

Name: gpr_issue_sched

Overview:
- Scoreboard-based issue controller that sequences access to the GPR file between the decode stage (IDU) and writeback (WBU).
- Tracks which architectural registers have a write pending and stalls IDU on RAW/WAW hazards or when the in-flight limit is reached.
- Hands accepted instructions to EXU through a valid/ready handshake.
- Drives the GPR write strobe and address from WBU retirements.

Parameters:
NR_REGS, 16, number of architectural GPRs (RV32E); register index width is 5 bits regardless.
MAX_INFLIGHT, 4, maximum instructions issued but not yet retired by WBU.
CNT_W, 32, width of the stall-cycle performance counter.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
idu_valid  in  1  IDU presents a decoded instruction.
idu_ready  out  1  scheduler can accept this cycle (combinational).
idu_rs1  in  5  source register 1 index.
idu_rs2  in  5  source register 2 index.
idu_rd  in  5  destination register index.
idu_rd_wen  in  1  instruction writes rd.
exu_valid  out  1  issued instruction held for EXU (registered).
exu_ready  in  1  EXU accepts issued instruction.
exu_rd  out  5  latched rd of issued instruction.
wbu_valid  in  1  WBU retires one instruction this cycle.
wbu_ready  out  1  constant 1, retirement never blocked.
wbu_rd  in  5  retiring destination index.
wbu_wen  in  1  retiring instruction writes rd.
gpr_wen  out  1  GPR write strobe (combinational).
gpr_waddr  out  5  GPR write address, equals wbu_rd.
busy_vec  out  NR_REGS  current scoreboard; bit 0 always 0.
inflight  out  3  current in-flight count, 0..MAX_INFLIGHT.
stall_cnt  out  CNT_W  cycles with idu_valid=1 and idu_ready=0.
sb_err  out  1  sticky: WBU wrote a register not marked busy.

Behaviour:
- Reset (async): state=IDLE, busy_vec=0, inflight=0, exu_valid=0, exu_rd=0, stall_cnt=0, sb_err=0.
- Reset mid-operation discards all latched and pending state immediately.
- hazard = (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]) | (idu_rd_wen & rd!=0 & busy[rd]) | (inflight==MAX_INFLIGHT).
- hazard is evaluated on registered busy/inflight only: no same-cycle bypass of a WBU clear. A register cleared at edge N is seen as free from cycle N+1.
- Indices >= NR_REGS are treated as not busy and never set.
- idu_ready = (state==IDLE) & ~hazard.
- FSM states:
  - IDLE: on idu_valid & idu_ready, latch exu_rd; set exu_valid=1; set busy[rd] if idu_rd_wen & rd!=0; inflight+1; go ISSUE. On idu_valid & hazard, go STALL.
  - STALL: idu_ready=0 for at least this cycle. If ~hazard, return to IDLE; idu_ready goes 1 next cycle. Minimum stall penalty is 1 cycle after hazard clears.
  - ISSUE: exu_valid held with exu_rd stable until exu_ready. On exu_ready, exu_valid=0 and go IDLE. Back-to-back issue therefore occurs every 2 cycles at best.
- Retirement on every wbu_valid cycle:
  - inflight-1, saturating at 0; if inflight is already 0, set sb_err.
  - If wbu_wen & wbu_rd!=0: clear busy[wbu_rd]; if that bit was already 0, set sb_err.
  - gpr_wen = wbu_valid & wbu_wen & (wbu_rd!=0); gpr_waddr = wbu_rd.
- Simultaneous issue and retire: inflight unchanged. Set and clear apply to different bits, since WAW blocks issuing to a busy rd. If they hit the same bit, the set wins.
- stall_cnt increments when idu_valid & ~idu_ready (including ISSUE wait cycles) and wraps at 2^CNT_W.
- x0 is never busy and never written.

Test Plan:
- Reset then idu_valid, rs1=1, rs2=2, rd=5, wen=1 -> idu_ready=1; next cycle exu_valid=1, exu_rd=5, busy_vec=0x0020, inflight=1.
- With x5 busy, issue rs1=5 -> idu_ready=0 and stall_cnt counts up. wbu_valid, rd=5, wen=1 -> gpr_wen=1, gpr_waddr=5; busy clears next edge; idu_ready=1 one cycle after STALL exits.
- Issue rd=0, wen=1 -> busy_vec stays 0, inflight=1. Retire it -> gpr_wen=0, inflight=0.
- Issue 4 independent instructions, rd=1..4, with exu_ready=1 -> 5th request stalls while inflight=4. A single retire -> 5th issues.
- Same cycle: issue rd=6 and retire rd=3 (busy) -> inflight unchanged, busy_vec bit6=1, bit3=0.
- wbu_valid, rd=7, wen=1 with x7 not busy -> sb_err=1 and stays 1. Assert rst mid-ISSUE -> all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/gpr_issue_sched_if.sv
// Handshake bundle between IDU, the issue scheduler, EXU and WBU.
// The master side is the pipeline around the scheduler; the slave side is the scheduler.
interface gpr_issue_sched_if;
  logic       idu_valid;
  logic       idu_ready;
  logic [4:0] idu_rs1;
  logic [4:0] idu_rs2;
  logic [4:0] idu_rd;
  logic       idu_rd_wen;
  logic       exu_valid;
  logic       exu_ready;
  logic [4:0] exu_rd;
  logic       wbu_valid;
  logic       wbu_ready;
  logic [4:0] wbu_rd;
  logic       wbu_wen;
  logic       gpr_wen;
  logic [4:0] gpr_waddr;

  modport master (
    output idu_valid, idu_rs1, idu_rs2, idu_rd, idu_rd_wen,
    output exu_ready, wbu_valid, wbu_rd, wbu_wen,
    input  idu_ready, exu_valid, exu_rd, wbu_ready, gpr_wen, gpr_waddr
  );

  modport slave (
    input  idu_valid, idu_rs1, idu_rs2, idu_rd, idu_rd_wen,
    input  exu_ready, wbu_valid, wbu_rd, wbu_wen,
    output idu_ready, exu_valid, exu_rd, wbu_ready, gpr_wen, gpr_waddr
  );
endinterface

// File: rtl/gpr_issue_sched.sv
// Scoreboard issue controller: stalls IDU on RAW/WAW hazards or a full in-flight window,
// hands instructions to EXU and turns WBU retirements into GPR write strobes.
module gpr_issue_sched #(
  parameter int NR_REGS      = 16,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  gpr_issue_sched_if.slave   bus,
  output logic [NR_REGS-1:0] busy_vec,
  output logic [2:0]         inflight,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic               sb_err
);

  typedef enum logic [1:0] {IDLE, STALL, ISSUE} state_t;

  state_t             state, state_nxt;
  logic [NR_REGS-1:0] busy, busy_nxt, set_mask, clr_mask;
  logic [2:0]         cnt, cnt_nxt;
  logic [4:0]         rd_q;
  logic               hazard, issue, dec, err_nxt, stall_cyc;

  // One-hot of a register index; x0 and indices beyond the file map to no bit.
  function automatic logic [NR_REGS-1:0] reg_mask(input logic [4:0] idx);
    reg_mask = '0;
    for (int i = 1; i < NR_REGS; i++)
      if (idx == 5'(i)) reg_mask[i] = 1'b1;
  endfunction

  function automatic logic is_busy(input logic [4:0] idx, input logic [NR_REGS-1:0] vec);
    is_busy = |(reg_mask(idx) & vec);
  endfunction

  // Hazards use registered state only, so a WBU clear is visible one cycle later.
  always_comb begin
    hazard = is_busy(bus.idu_rs1, busy) | is_busy(bus.idu_rs2, busy)
           | (bus.idu_rd_wen & is_busy(bus.idu_rd, busy))
           | (cnt == 3'(MAX_INFLIGHT));
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.idu_valid) begin
          if (!hazard) begin
            issue     = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = STALL;
          end
        end
      end
      STALL:   if (!hazard) state_nxt = IDLE;
      ISSUE:   if (bus.exu_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Set is applied after clear so a same-bit collision leaves the bit busy.
  always_comb begin
    set_mask  = (issue && bus.idu_rd_wen) ? reg_mask(bus.idu_rd) : '0;
    clr_mask  = (bus.wbu_valid && bus.wbu_wen) ? reg_mask(bus.wbu_rd) : '0;
    busy_nxt  = (busy & ~clr_mask) | set_mask;
    dec       = bus.wbu_valid & (cnt != 3'd0);
    cnt_nxt   = cnt + {2'b00, issue} - {2'b00, dec};
    err_nxt   = bus.wbu_valid & ((cnt == 3'd0)
              | (bus.wbu_wen & (bus.wbu_rd != 5'd0) & ~is_busy(bus.wbu_rd, busy)));
    stall_cyc = bus.idu_valid & ~bus.idu_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= '0;
      cnt       <= '0;
      rd_q      <= '0;
      stall_cnt <= '0;
      sb_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      cnt   <= cnt_nxt;
      if (issue) rd_q <= bus.idu_rd;
      if (stall_cyc) stall_cnt <= stall_cnt + CNT_W'(1);
      if (err_nxt) sb_err <= 1'b1;
    end
  end

  assign bus.idu_ready = (state == IDLE) & ~hazard;
  assign bus.exu_valid = (state == ISSUE);
  assign bus.exu_rd    = rd_q;
  assign bus.wbu_ready = 1'b1;
  assign bus.gpr_wen   = bus.wbu_valid & bus.wbu_wen & (bus.wbu_rd != 5'd0);
  assign bus.gpr_waddr = bus.wbu_rd;
  assign busy_vec      = busy;
  assign inflight      = cnt;

endmodule
